uart_tx_buffered: RTL
=====================

Name: uart_tx_buffered

Overview:
UART transmitter with a small input FIFO. Serialises 8N1 frames (1 start, 8 data LSB-first, 1 stop) onto `tx`. It is the transmit-side counterpart to the UART receive path in the loopback design. The upstream logic pushes bytes through a valid/ready handshake, and the block drains them back-to-back without idle gaps.

Parameters:
- CLKS_PER_BIT, 10417, clock cycles per bit (100 MHz / 9600 baud); must be >= 2
- FIFO_DEPTH, 4, number of FIFO entries; power of two, >= 2

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- tx_data  in  8  byte to send
- tx_valid  in  1  upstream offers tx_data this cycle
- tx_ready  out  1  FIFO can accept a byte (= not full)
- tx  out  1  serial line, idle high
- busy  out  1  high while a frame is on the line (state != IDLE)
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of bytes queued, excluding the byte being shifted

Behaviour:
- Reset (async, active-high):
  - tx=1, busy=0, tx_ready=1, fifo_count=0, state=IDLE.
  - FIFO pointers, bit counter and baud counter are all cleared.
  - Any in-progress frame is abandoned; tx is forced to 1 immediately, not at the next edge.
- Push:
  - A byte is accepted on a rising edge where tx_valid && tx_ready.
  - tx_ready = (fifo_count != FIFO_DEPTH). It is combinational from registered count and does not depend on tx_valid.
  - tx_valid while full: the byte is dropped, with no state change. Upstream must hold it.
- Pop: the FIFO head is popped into an 8-bit shift register when the FSM launches a frame.
- Simultaneous push and pop in one cycle: both happen; fifo_count is unchanged. Push at full is never possible, because tx_ready=0 even if a pop occurs that cycle.
- All outputs are registered except tx_ready. tx comes directly from a flop.
- Baud counter runs 0..CLKS_PER_BIT-1. Each bit (start, data, stop) holds tx stable for exactly CLKS_PER_BIT cycles.
- FSM states:
  - IDLE:
    - tx=1.
    - If fifo_count>0: pop, load shift reg, go START; tx=0 from the next edge.
  - START:
    - tx=0 for CLKS_PER_BIT cycles, then go DATA with bit index 0.
  - DATA:
    - tx = shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index.
    - After index 7 completes, go STOP.
  - STOP:
    - tx=1 for CLKS_PER_BIT cycles.
    - On the last cycle: if fifo_count>0, pop and go START directly; tx=0 on the next edge, so there are no gap cycles.
    - Otherwise go IDLE.
- Latency:
  - The byte is accepted into an empty FIFO in IDLE at edge k.
  - At edge k+1 the FSM pops and tx falls.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have start-bit falling edges exactly 10*CLKS_PER_BIT cycles apart.
- busy:
  - Rises on the same edge tx first falls.
  - Falls on the edge STOP→IDLE.
  - Stays 1 across back-to-back frames.
- FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap naturally; full/empty are derived from fifo_count.
- Bytes leave strictly in push order. No byte is duplicated or lost across wrap-around.

Test Plan:
1. Use CLKS_PER_BIT=16. Push 0x55 once from idle.
   - tx falls 1 edge after acceptance.
   - Line sequence, 16 cycles each: 0,1,0,1,0,1,0,1,0,1.
   - busy is high for exactly 160 cycles, then tx=1, busy=0.
2. Push 0x55 then 0x00 on consecutive cycles.
   - Second start bit falls exactly 160 cycles after the first.
   - Second frame is 0 followed by eight 0s, then stop 1.
   - busy never drops between frames; fifo_count goes 1→0 at the second launch.
3. Hold tx_valid high with bytes 0x01..0x06, FIFO_DEPTH=4.
   - First byte pops immediately, then the FIFO fills to count 4 and tx_ready=0.
   - Remaining bytes are accepted only as frames launch.
   - Six frames emerge in order 0x01..0x06 with no gaps.
4. With FIFO full, push on the exact edge STOP launches the next frame.
   - tx_ready is 0 that cycle, so the byte is not accepted.
   - fifo_count goes 4→3, and tx_ready=1 on the next cycle.
5. With count=2 and tx_valid asserted, push on the same edge as a pop.
   - fifo_count stays 2 and order is preserved.
6. Assert reset mid-DATA of 0xA3 with 2 bytes queued.
   - tx=1 and busy=0 immediately (asynchronously); fifo_count=0.
   - After release, no residual frame appears.
   - A fresh push of 0xA3 yields data bits 1,1,0,0,0,1,0,1.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed from a small FIFO through a valid/ready push port.
// Frames are drained back-to-back: STOP hands straight to START when a byte is waiting.
module uart_tx_buffered #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [7:0]                         tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic                               tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];

  logic            push;
  logic            pop;
  logic            baud_last;
  logic            have_byte;

  assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  assign push      = tx_valid && tx_ready;
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign have_byte = (count_q != '0);

  // Frame sequencer: each line level is held for one full baud period.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_last ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (have_byte) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_last) begin
          if (have_byte) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FIFO bookkeeping; pointers wrap on their natural width.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = tx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule
